// File: rtl/pc_fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its neighbours: PC block,
// instruction memory port, decoder and the control-flow event sources.
interface pc_fetch_sequencer_if;
  logic [31:0] pc;
  logic        pc_enable;
  logic        pc_override;
  logic [31:0] pc_value;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        halt;
  logic        misaligned;

  modport master (
    input  pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_target, trap, halt,
    output pc_enable, pc_override, pc_value, imem_req_valid, imem_addr,
           inst_valid, inst_data, inst_pc, misaligned
  );

  modport slave (
    output pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_target, trap, halt,
    input  pc_enable, pc_override, pc_value, imem_req_valid, imem_addr,
           inst_valid, inst_data, inst_pc, misaligned
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: steers the PC block, keeps one instruction fetch in flight
// and holds the returned instruction until the decoder takes it.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_fetch_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t      state_r, next_state_s;
  logic        kill_r, kill_nxt_s;
  logic [31:0] req_pc_r, req_pc_nxt_s;
  logic        inst_valid_r, inst_valid_nxt_s;
  logic [31:0] inst_data_r, inst_data_nxt_s;
  logic [31:0] inst_pc_r, inst_pc_nxt_s;
  logic        misaligned_r, misaligned_nxt_s;

  logic        pc_enable_s, pc_override_s, req_valid_s;
  logic [31:0] pc_value_s;

  logic        evt_active_s, take_trap_s, take_redir_s, redir_misaligned_s, evt_s;
  logic [31:0] target_s;

  // Trap wins over redirect; events are ignored while booting.
  assign evt_active_s       = (state_r != BOOT);
  assign take_trap_s        = bus.trap && evt_active_s;
  assign take_redir_s       = bus.redirect_valid && !bus.trap && evt_active_s;
  assign redir_misaligned_s = take_redir_s && (bus.redirect_target[1:0] != 2'b00);
  assign evt_s              = take_trap_s || take_redir_s;
  assign target_s           = (take_trap_s || redir_misaligned_s) ? TRAP_VECTOR
                                                                  : bus.redirect_target;

  // Next-state, PC-block controls and buffer updates.
  always_comb begin
    next_state_s     = state_r;
    kill_nxt_s       = kill_r;
    req_pc_nxt_s     = req_pc_r;
    inst_valid_nxt_s = inst_valid_r;
    inst_data_nxt_s  = inst_data_r;
    inst_pc_nxt_s    = inst_pc_r;
    misaligned_nxt_s = redir_misaligned_s;
    pc_enable_s      = 1'b0;
    pc_override_s    = 1'b0;
    pc_value_s       = 32'h0000_0000;
    req_valid_s      = 1'b0;

    if (rst) begin
      next_state_s     = BOOT;
      misaligned_nxt_s = 1'b0;
    end else begin
      // A control-flow event owns the PC controls for this cycle.
      if (evt_s) begin
        pc_enable_s   = 1'b1;
        pc_override_s = 1'b1;
        pc_value_s    = target_s;
      end else begin
        pc_value_s    = 32'h0000_0000;
      end

      case (state_r)
        BOOT: begin
          pc_enable_s   = 1'b1;
          pc_override_s = 1'b1;
          pc_value_s    = RESET_VECTOR;
          next_state_s  = REQ;
        end
        REQ: begin
          if (evt_s) begin
            next_state_s = REQ;
          end else begin
            req_valid_s = 1'b1;
            if (bus.imem_req_ready) begin
              req_pc_nxt_s = bus.pc;
              pc_enable_s  = 1'b1;
              next_state_s = WAIT;
            end else if (bus.halt) begin
              next_state_s = HALTED;
            end else begin
              next_state_s = REQ;
            end
          end
        end
        WAIT: begin
          if (evt_s) begin
            if (bus.imem_rsp_valid) begin
              kill_nxt_s   = 1'b0;
              next_state_s = REQ;
            end else begin
              kill_nxt_s   = 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            if (kill_r) begin
              kill_nxt_s   = 1'b0;
              next_state_s = REQ;
            end else begin
              inst_data_nxt_s  = bus.imem_rsp_data;
              inst_pc_nxt_s    = req_pc_r;
              inst_valid_nxt_s = 1'b1;
              next_state_s     = HOLD;
            end
          end else begin
            next_state_s = WAIT;
          end
        end
        HOLD: begin
          if (evt_s) begin
            inst_valid_nxt_s = 1'b0;
            next_state_s     = REQ;
          end else if (bus.inst_ready) begin
            inst_valid_nxt_s = 1'b0;
            next_state_s     = bus.halt ? HALTED : REQ;
          end else begin
            next_state_s = HOLD;
          end
        end
        HALTED: begin
          if (evt_s) begin
            next_state_s = HALTED;
          end else if (!bus.halt) begin
            next_state_s = REQ;
          end else begin
            next_state_s = HALTED;
          end
        end
        default: begin
          next_state_s = BOOT;
        end
      endcase
    end
  end

  // State, kill flag and instruction buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= BOOT;
      kill_r       <= 1'b0;
      req_pc_r     <= 32'h0000_0000;
      inst_valid_r <= 1'b0;
      inst_data_r  <= 32'h0000_0000;
      inst_pc_r    <= 32'h0000_0000;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      kill_r       <= kill_nxt_s;
      req_pc_r     <= req_pc_nxt_s;
      inst_valid_r <= inst_valid_nxt_s;
      inst_data_r  <= inst_data_nxt_s;
      inst_pc_r    <= inst_pc_nxt_s;
      misaligned_r <= misaligned_nxt_s;
    end
  end

  assign bus.pc_enable      = pc_enable_s;
  assign bus.pc_override    = pc_override_s;
  assign bus.pc_value       = pc_value_s;
  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_addr      = req_valid_s ? bus.pc : 32'h0000_0000;
  assign bus.inst_valid     = inst_valid_r;
  assign bus.inst_data      = inst_data_r;
  assign bus.inst_pc        = inst_pc_r;
  assign bus.misaligned     = misaligned_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a behavioural PC block and a
// single-outstanding instruction memory whose data is {addr[15:0], 16'hBEEF}.
module tb_pc_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_model = 32'h0000_0000;
  logic        mem_ready = 1'b1;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0000_0000;

  pc_fetch_sequencer_if bus_if();

  pc_fetch_sequencer #(
    .RESET_VECTOR(32'h0000_1000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.pc             = pc_model;
  assign bus_if.imem_req_ready = mem_ready;
  assign bus_if.imem_rsp_valid = (mem_cnt == 1);
  assign bus_if.imem_rsp_data  = {mem_addr[15:0], 16'hBEEF};

  // PC block and memory models
  always @(posedge clk) begin
    if (bus_if.pc_enable)
      pc_model <= bus_if.pc_override ? bus_if.pc_value : pc_model + 32'd4;
    if (bus_if.imem_req_valid && mem_ready) begin
      mem_cnt  <= mem_lat;
      mem_addr <= bus_if.imem_addr;
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; single-cycle pulses drop right after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus_if.redirect_valid = 1'b0;
    bus_if.trap           = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.inst_ready      = 1'b1;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_target = 32'h0000_0000;
    bus_if.trap            = 1'b0;
    bus_if.halt            = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc_enable", {31'd0, bus_if.pc_enable}, 32'd0);
    chk("rst_req_valid", {31'd0, bus_if.imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("rst_inst_data", bus_if.inst_data, 32'h0);
    chk("rst_misaligned", {31'd0, bus_if.misaligned}, 32'd0);

    // boot cycle, then first request
    rst = 1'b0;
    #1;
    chk("boot_pc_enable", {31'd0, bus_if.pc_enable}, 32'd1);
    chk("boot_pc_override", {31'd0, bus_if.pc_override}, 32'd1);
    chk("boot_pc_value", bus_if.pc_value, 32'h0000_1000);
    chk("boot_no_req", {31'd0, bus_if.imem_req_valid}, 32'd0);
    step();
    chk("req0_valid", {31'd0, bus_if.imem_req_valid}, 32'd1);
    chk("req0_addr", bus_if.imem_addr, 32'h0000_1000);
    chk("req0_incr_en", {31'd0, bus_if.pc_enable}, 32'd1);
    chk("req0_incr_ovr", {31'd0, bus_if.pc_override}, 32'd0);
    step();
    chk("wait0_no_req", {31'd0, bus_if.imem_req_valid}, 32'd0);
    chk("wait0_pc", bus_if.pc, 32'h0000_1004);
    chk("wait0_inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    step();
    chk("hold0_valid", {31'd0, bus_if.inst_valid}, 32'd1);
    chk("hold0_pc", bus_if.inst_pc, 32'h0000_1000);
    chk("hold0_data", bus_if.inst_data, 32'h1000_BEEF);
    step();
    chk("req1_addr", bus_if.imem_addr, 32'h0000_1004);
    step();
    step();
    chk("hold1_pc", bus_if.inst_pc, 32'h0000_1004);
    chk("hold1_data", bus_if.inst_data, 32'h1004_BEEF);
    step();
    chk("req2_addr", bus_if.imem_addr, 32'h0000_1008);

    // backpressure
    bus_if.inst_ready = 1'b0;
    step();
    step();
    chk("bp_valid", {31'd0, bus_if.inst_valid}, 32'd1);
    chk("bp_pc", bus_if.inst_pc, 32'h0000_1008);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, bus_if.inst_valid}, 32'd1);
      chk("bp_hold_data", bus_if.inst_data, 32'h1008_BEEF);
      chk("bp_hold_ipc", bus_if.inst_pc, 32'h0000_1008);
      chk("bp_no_req", {31'd0, bus_if.imem_req_valid}, 32'd0);
      chk("bp_pc_held", bus_if.pc, 32'h0000_100C);
    end
    bus_if.inst_ready = 1'b1;
    step();
    chk("bp_release_addr", bus_if.imem_addr, 32'h0000_100C);

    // redirect in REQ to 0x2000, then redirect in WAIT to 0x3000
    bus_if.redirect_valid  = 1'b1;
    bus_if.redirect_target = 32'h0000_2000;
    #1;
    chk("rdq_pc_value", bus_if.pc_value, 32'h0000_2000);
    chk("rdq_req_forced0", {31'd0, bus_if.imem_req_valid}, 32'd0);
    step();
    chk("req2000_addr", bus_if.imem_addr, 32'h0000_2000);
    mem_lat = 3;
    step();
    bus_if.redirect_valid  = 1'b1;
    bus_if.redirect_target = 32'h0000_3000;
    #1;
    chk("rdw_pc_enable", {31'd0, bus_if.pc_enable}, 32'd1);
    chk("rdw_pc_override", {31'd0, bus_if.pc_override}, 32'd1);
    chk("rdw_pc_value", bus_if.pc_value, 32'h0000_3000);
    step();
    chk("rdw_kill_no_inst", {31'd0, bus_if.inst_valid}, 32'd0);
    step();
    chk("rdw_rsp_dropped_req", {31'd0, bus_if.imem_req_valid}, 32'd0);
    step();
    chk("rdw_no_inst", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("rdw_next_addr", bus_if.imem_addr, 32'h0000_3000);
    mem_lat = 1;
    step();
    step();
    chk("hold3000_pc", bus_if.inst_pc, 32'h0000_3000);

    // misaligned redirect in HOLD
    bus_if.inst_ready      = 1'b0;
    bus_if.redirect_valid  = 1'b1;
    bus_if.redirect_target = 32'h0000_3002;
    #1;
    chk("mis_pc_value", bus_if.pc_value, 32'h0000_0100);
    step();
    bus_if.inst_ready = 1'b1;
    chk("mis_flush", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("mis_pulse", {31'd0, bus_if.misaligned}, 32'd1);
    chk("mis_addr", bus_if.imem_addr, 32'h0000_0100);
    step();
    chk("mis_pulse_end", {31'd0, bus_if.misaligned}, 32'd0);
    step();
    chk("hold100_pc", bus_if.inst_pc, 32'h0000_0100);
    step();
    chk("req104_addr", bus_if.imem_addr, 32'h0000_0104);

    // trap and redirect together
    bus_if.trap            = 1'b1;
    bus_if.redirect_valid  = 1'b1;
    bus_if.redirect_target = 32'h0000_4000;
    #1;
    chk("trap_pc_value", bus_if.pc_value, 32'h0000_0100);
    chk("trap_req_forced0", {31'd0, bus_if.imem_req_valid}, 32'd0);
    step();
    chk("trap_addr", bus_if.imem_addr, 32'h0000_0100);
    chk("trap_no_mis", {31'd0, bus_if.misaligned}, 32'd0);
    step();
    step();
    chk("hold_trap_data", bus_if.inst_data, 32'h0100_BEEF);

    // halt while holding, then consume
    bus_if.halt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_no_req", {31'd0, bus_if.imem_req_valid}, 32'd0);
      chk("halt_pc_held", bus_if.pc, 32'h0000_0104);
      chk("halt_pc_enable", {31'd0, bus_if.pc_enable}, 32'd0);
    end
    bus_if.halt = 1'b0;
    step();
    chk("resume_valid", {31'd0, bus_if.imem_req_valid}, 32'd1);
    chk("resume_addr", bus_if.imem_addr, 32'h0000_0104);

    // reset asserted while waiting on a slow response
    mem_lat = 3;
    step();
    rst = 1'b1;
    #1;
    chk("arst_pc_enable", {31'd0, bus_if.pc_enable}, 32'd0);
    chk("arst_pc_override", {31'd0, bus_if.pc_override}, 32'd0);
    chk("arst_pc_value", bus_if.pc_value, 32'h0);
    chk("arst_req_valid", {31'd0, bus_if.imem_req_valid}, 32'd0);
    chk("arst_addr", bus_if.imem_addr, 32'h0);
    chk("arst_inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("arst_inst_data", bus_if.inst_data, 32'h0);
    chk("arst_inst_pc", bus_if.inst_pc, 32'h0);
    chk("arst_misaligned", {31'd0, bus_if.misaligned}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reboot_pc_value", bus_if.pc_value, 32'h0000_1000);
    chk("reboot_no_req", {31'd0, bus_if.imem_req_valid}, 32'd0);
    step();
    chk("reboot_no_inst", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("reboot_addr", bus_if.imem_addr, 32'h0000_1000);
    mem_lat = 1;
    step();
    step();
    chk("reboot_inst_pc", bus_if.inst_pc, 32'h0000_1000);
    chk("reboot_inst_data", bus_if.inst_data, 32'h1000_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
